// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared types and widths for the DRAM arbiter slice
package dram_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 4;
   localparam int ROW_W  = 8;
   localparam int COL_W  = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

   // Pointer width that stays legal when only one requester exists.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/dram_rr_pick.sv
// rtl/dram_rr_pick.sv - round-robin pick: first valid index at or after the pointer
module dram_rr_pick
   import dram_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int PTR_W = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0]  i_valid,
   input  logic [PTR_W-1:0] i_ptr,
   output logic             o_any,
   output logic [PTR_W-1:0] o_g
);
   // Walk farthest-to-nearest so the nearest valid index overwrites the result last.
   always_comb begin
      o_any = 1'b0;
      o_g   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(i_ptr) + k) % NREQ;
         if (i_valid[idx]) begin
            o_any = 1'b1;
            o_g   = PTR_W'(idx);
         end
      end
   end
endmodule

// File: rtl/dram_arb.sv
// rtl/dram_arb.sv - round-robin sequencer sharing one DRAM controller among requesters
module dram_arb
   import dram_pkg::*;
#(
   parameter int NREQ        = 2,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_write,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic [ADDR_W-1:0]      mem_addr,
   output logic                   mem_write,
   output logic                   mem_ena,
   output logic [DATA_W-1:0]      mem_wdata,
   input  logic                   mem_busy,
   input  logic                   mem_ack,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   timeout_err
);
   localparam int PTR_W = ptr_width(NREQ);

   arb_state_t         r_state, w_next;
   logic [PTR_W-1:0]   r_ptr, r_g, w_g;
   logic               w_any;
   logic [7:0]         r_tcnt;
   logic [NREQ-1:0]    r_req_ready, r_rsp_valid;
   logic [DATA_W-1:0]  r_rsp_rdata, r_mem_wdata;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic               r_mem_write, r_mem_ena, r_timeout_err;

   dram_rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_any   (w_any),
      .o_g     (w_g)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_any && !mem_busy) w_next = ISSUE;
         ISSUE:   if (mem_ack) w_next = WAIT;
         WAIT:    if (!mem_busy) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr         <= '0;
         r_g           <= '0;
         r_tcnt        <= '0;
         r_req_ready   <= '0;
         r_rsp_valid   <= '0;
         r_rsp_rdata   <= '0;
         r_mem_addr    <= '0;
         r_mem_write   <= 1'b0;
         r_mem_ena     <= 1'b0;
         r_mem_wdata   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_req_ready <= '0;
         r_rsp_valid <= '0;
         case (r_state)
            IDLE: begin
               if (w_any && !mem_busy) begin
                  r_mem_addr  <= req_addr[ADDR_W*int'(w_g) +: ADDR_W];
                  r_mem_wdata <= req_wdata[DATA_W*int'(w_g) +: DATA_W];
                  r_mem_write <= req_write[w_g];
                  r_mem_ena   <= 1'b1;
                  r_req_ready <= NREQ'(1) << w_g;
                  r_ptr       <= (int'(w_g) == NREQ - 1) ? '0 : w_g + 1'b1;
                  r_g         <= w_g;
                  r_tcnt      <= '0;
               end
            end
            ISSUE: begin
               // Late ack only flags an error; refresh or init can legitimately stall it.
               if (mem_ack) begin
                  r_mem_ena <= 1'b0;
               end else begin
                  if (r_tcnt != 8'(ACK_TIMEOUT)) r_tcnt <= r_tcnt + 8'd1;
                  if (r_tcnt == 8'(ACK_TIMEOUT - 1)) r_timeout_err <= 1'b1;
               end
            end
            WAIT: begin
               if (!mem_busy) begin
                  r_rsp_valid <= NREQ'(1) << r_g;
                  if (!r_mem_write) r_rsp_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign mem_addr    = r_mem_addr;
   assign mem_write   = r_mem_write;
   assign mem_ena     = r_mem_ena;
   assign mem_wdata   = r_mem_wdata;
   assign timeout_err = r_timeout_err;
endmodule

// File: tb/tb_dram_arb.sv
// tb/tb_dram_arb.sv - scoreboard bench for dram_arb with a refresh-timed controller stub
module tb_dram_arb;
   localparam int NREQ    = 2;
   localparam int CMD_LEN = 6;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '0;
   logic [NREQ-1:0]      req_write = '0;
   logic [NREQ*16-1:0]   req_addr  = '0;
   logic [NREQ*4-1:0]    req_wdata = '0;
   logic [NREQ-1:0]      req_ready, rsp_valid;
   logic [3:0]           rsp_rdata, mem_wdata;
   logic [15:0]          mem_addr;
   logic                 mem_write, mem_ena, timeout_err;
   logic                 mem_busy  = 1'b0;
   logic                 mem_ack   = 1'b0;
   logic [3:0]           mem_rdata = 4'h0;

   dram_arb #(.NREQ(NREQ), .ACK_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
      .mem_write(mem_write), .mem_ena(mem_ena), .mem_wdata(mem_wdata),
      .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Controller stub: refresh due every 781 cycles takes priority and lasts 10 cycles.
   int         rf_cnt = 0;
   int         s_cnt  = 0;
   int         ncmd   = 0;
   bit         s_pend = 1'b0;
   bit         s_ref  = 1'b0;
   bit         s_init = 1'b0;
   bit         no_ack = 1'b0;
   logic [3:0] smem [0:65535];

   always @(posedge clk) begin
      mem_ack <= 1'b0;
      if (!s_init) begin
         smem[16'h0005] <= 4'h6;
         s_init <= 1'b1;
      end
      rf_cnt <= (rf_cnt == 780) ? 0 : rf_cnt + 1;
      if (rf_cnt == 780) s_pend <= 1'b1;
      if (s_cnt > 0) begin
         s_cnt <= s_cnt - 1;
         if (s_cnt == 1) begin
            mem_busy <= 1'b0;
            s_ref    <= 1'b0;
         end
      end else if (s_pend || rf_cnt == 780) begin
         mem_busy <= 1'b1;
         s_ref    <= 1'b1;
         s_cnt    <= 10;
         s_pend   <= 1'b0;
      end else if (mem_ena && !no_ack) begin
         mem_busy <= 1'b1;
         mem_ack  <= 1'b1;
         s_cnt    <= CMD_LEN;
         ncmd     <= ncmd + 1;
         if (mem_write) smem[mem_addr] <= mem_wdata;
         else           mem_rdata <= smem[mem_addr];
      end
   end

   typedef struct {
      int         idx;
      bit         rd;
      logic [3:0] data;
   } rsp_t;

   rsp_t rq[$];
   int   gq[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   always @(negedge clk) begin
      rsp_t e;
      int   g;
      if (req_ready != '0) begin
         if (gq.size() == 0) begin
            check("unexpected_grant", 32'(req_ready), 32'd0);
         end else begin
            g = gq.pop_front();
            check("grant_order", 32'(req_ready), 32'(1 << g));
         end
      end
      if (rsp_valid != '0) begin
         if (rq.size() == 0) begin
            check("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            e = rq.pop_front();
            check("rsp_target", 32'(rsp_valid), 32'(1 << e.idx));
            if (e.rd) check("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
         end
      end
   end

   task automatic set_req(input int i, input bit wr, input logic [15:0] a, input logic [3:0] d);
      req_write[i]       = wr;
      req_addr[16*i +: 16] = a;
      req_wdata[4*i +: 4]  = d;
   endtask

   task automatic issue(input int i, input bit wr, input logic [15:0] a, input logic [3:0] d,
                        input bit want_rsp, input logic [3:0] exp_rd, output int waited);
      rsp_t e;
      set_req(i, wr, a, d);
      gq.push_back(i);
      if (want_rsp) begin
         e.idx = i; e.rd = !wr; e.data = exp_rd;
         rq.push_back(e);
      end
      req_valid[i] = 1'b1;
      waited = 0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (req_ready[i]) begin
            waited = c;
            break;
         end
      end
      req_valid[i] = 1'b0;
      check("grant_wait", 32'(waited != 0), 32'd1);
   endtask

   task automatic wait_rsp(input int i, input bit hold, input logic [15:0] a, input logic [3:0] d);
      bit got = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (hold && mem_busy) begin
            check("hold_addr", 32'(mem_addr), 32'(a));
            check("hold_wdata", 32'(mem_wdata), 32'(d));
         end
         if (rsp_valid[i]) begin
            got = 1'b1;
            break;
         end
      end
      check("rsp_wait", 32'(got), 32'd1);
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
      check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
      check({tag, "_mem_ena"}, 32'(mem_ena), 32'd0);
      check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
   endtask

   initial begin
      int lat, ng, n0;
      bit found, pb;
      rsp_t e;

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;

      // single read, one-cycle grant latency
      issue(0, 1'b0, 16'h0005, 4'h0, 1'b1, 4'h6, lat);
      check("t1_latency", 32'(lat), 32'd1);
      check("t1_mem_ena", 32'(mem_ena), 32'd1);
      check("t1_mem_addr", 32'(mem_addr), 32'h0005);
      wait_rsp(0, 1'b0, 16'h0, 4'h0);

      // writes then reads, command fields held while the controller is busy
      issue(1, 1'b1, 16'h00FF, 4'h0, 1'b1, 4'h0, lat);
      wait_rsp(1, 1'b1, 16'h00FF, 4'h0);
      check("t3_rdata_held_on_write", 32'(rsp_rdata), 32'h6);
      issue(0, 1'b1, 16'h1234, 4'hA, 1'b1, 4'h0, lat);
      wait_rsp(0, 1'b1, 16'h1234, 4'hA);
      issue(1, 1'b0, 16'h00FF, 4'h9, 1'b1, 4'h0, lat);
      wait_rsp(1, 1'b0, 16'h0, 4'h0);
      issue(1, 1'b0, 16'h1234, 4'h0, 1'b1, 4'hA, lat);
      wait_rsp(1, 1'b0, 16'h0, 4'h0);

      // contention from reset: both held, grants alternate 0,1,0,1
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b0, 16'h1234, 4'h0);
      set_req(1, 1'b0, 16'h0005, 4'h0);
      for (int k = 0; k < 4; k++) begin
         gq.push_back(k % 2);
         e.idx = k % 2; e.rd = 1'b1; e.data = (k % 2 == 0) ? 4'hA : 4'h6;
         rq.push_back(e);
      end
      req_valid = 2'b11;
      ng = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (req_ready != '0) ng++;
         if (ng == 4) break;
      end
      req_valid = 2'b00;
      check("t2_grant_count", 32'(ng), 32'd4);
      for (int c = 0; c < 300; c++) begin
         if (rq.size() == 0) break;
         @(negedge clk);
      end
      check("t2_drained", 32'(rq.size()), 32'd0);

      // grant lands one cycle before refresh is due
      found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (rf_cnt == 779 && !mem_busy) begin
            found = 1'b1;
            break;
         end
      end
      check("t4_refresh_window", 32'(found), 32'd1);
      n0 = ncmd;
      issue(0, 1'b0, 16'h0005, 4'h0, 1'b1, 4'h6, lat);
      @(negedge clk);
      check("t4_refresh_active", 32'(s_ref), 32'd1);
      check("t4_ena_held", 32'(mem_ena), 32'd1);
      wait_rsp(0, 1'b0, 16'h0, 4'h0);
      repeat (3) @(negedge clk);
      check("t4_one_command", 32'(ncmd - n0), 32'd1);
      check("t4_ena_low", 32'(mem_ena), 32'd0);
      check("t4_no_extra_rsp", 32'(rq.size()), 32'd0);

      // reset while waiting for completion
      issue(0, 1'b0, 16'h0005, 4'h0, 1'b0, 4'h0, lat);
      for (int c = 0; c < 50; c++) begin
         if (!mem_ena) break;
         @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      chk_idle("t6");
      rst = 1'b0;
      set_req(1, 1'b0, 16'h1234, 4'h0);
      gq.push_back(1);
      e.idx = 1; e.rd = 1'b1; e.data = 4'hA;
      rq.push_back(e);
      req_valid[1] = 1'b1;
      pb = mem_busy;
      found = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (req_ready[1]) begin
            found = 1'b1;
            break;
         end
         pb = mem_busy;
      end
      req_valid[1] = 1'b0;
      check("t6_grant", 32'(found), 32'd1);
      check("t6_busy_before_grant", 32'(pb), 32'd0);
      wait_rsp(1, 1'b0, 16'h0, 4'h0);

      // controller never acks: error after 255 ISSUE cycles, sticky until reset
      no_ack = 1'b1;
      issue(1, 1'b1, 16'h0042, 4'h3, 1'b0, 4'h0, lat);
      repeat (254) @(negedge clk);
      check("t5_not_yet", 32'(timeout_err), 32'd0);
      @(negedge clk);
      check("t5_timeout", 32'(timeout_err), 32'd1);
      repeat (100) @(negedge clk);
      check("t5_sticky", 32'(timeout_err), 32'd1);
      check("t5_ena_kept", 32'(mem_ena), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("t5_reset");
      rst = 1'b0;
      no_ack = 1'b0;
      repeat (3) @(negedge clk);

      check("grant_queue_empty", 32'(gq.size()), 32'd0);
      check("rsp_queue_empty", 32'(rq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
